// File: rtl/bcd_digit_encoder_pkg.sv
// rtl/bcd_digit_encoder_pkg.sv - shared types and constants for the BCD digit encoder
package bcd_digit_encoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Any code above 9 is shown as a blank digit by the downstream decoders.
    localparam logic [3:0] BCD_BLANK       = 4'hF;
    localparam logic [3:0] BCD_ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble digit correction (add 3 when digit >= 5)
//
// Ports:
//   i_digit  BCD digit before the shift
//   o_digit  corrected digit; a legal digit (0..9) never carries out of 4 bits
module bcd_add3
    import bcd_digit_encoder_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= BCD_ADD3_THRESH) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bcd_digit_encoder.sv
// rtl/bcd_digit_encoder.sv - sequential binary-to-BCD converter (shift-add-3, one bit per clock)
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_in_valid   i_in_data is valid
//   o_in_ready   converter idle and able to accept a value
//   i_in_data    unsigned binary value
//   o_out_valid  result available (DONE state)
//   i_out_ready  consumer acknowledges the result
//   o_bcd_out    packed BCD, digit k in bits [4k+3:4k], ones digit lowest
//   o_overflow   last accepted value exceeded 10^DIGITS - 1 (digits saturate to 9)
//
// Optional build macro: BCD_LEADING_ZERO_BLANK_EN - leading zero digits above the
// most significant nonzero digit are output as 4'hF; digit 0 is never blanked.
module bcd_digit_encoder
    import bcd_digit_encoder_pkg::*;
#(
    parameter int IN_WIDTH = 11,
    parameter int DIGITS   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [IN_WIDTH-1:0]   i_in_data,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [4*DIGITS-1:0]   o_bcd_out,
    output logic                  o_overflow
);

    localparam int          BCD_W   = 4 * DIGITS;
    localparam int          SR_W    = BCD_W + IN_WIDTH;
    localparam int          CNT_W   = $clog2(IN_WIDTH + 1);
    localparam int unsigned MAX_VAL = 10**DIGITS - 1;
    // Compare in a width that holds both the input and the limit.
    localparam int          CMP_W   = (IN_WIDTH > 32) ? IN_WIDTH : 32;

`ifdef BCD_LEADING_ZERO_BLANK_EN
    localparam logic [BCD_W-1:0] BCD_RST = {{(DIGITS-1){BCD_BLANK}}, 4'h0};
`else
    localparam logic [BCD_W-1:0] BCD_RST = '0;
`endif

    state_t             r_state;
    state_t             w_next;
    logic [SR_W-1:0]    r_sr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf_flag;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_overflow;

    logic               w_over;
    logic               w_last;
    logic [BCD_W-1:0]   w_adj;
    logic [SR_W-1:0]    w_shifted;
    logic [BCD_W-1:0]   w_conv;
    logic [BCD_W-1:0]   w_result;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic               w_lead;
`endif

    assign w_over = CMP_W'(i_in_data) > CMP_W'(MAX_VAL);
    assign w_last = (r_cnt == CNT_W'(1));

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_add3
            bcd_add3 u_add3 (
                .i_digit (r_sr[IN_WIDTH + 4*g +: 4]),
                .o_digit (w_adj[4*g +: 4])
            );
        end
    endgenerate

    // Corrected digits and the binary part shift together; the top BCD bit falls off.
    assign w_shifted = {w_adj[BCD_W-2:0], r_sr[IN_WIDTH-1:0], 1'b0};
    assign w_conv    = w_shifted[SR_W-1 -: BCD_W];

    always_comb begin
        w_result = w_conv;
`ifdef BCD_LEADING_ZERO_BLANK_EN
        w_lead = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (w_lead && (w_conv[4*k +: 4] == 4'd0)) begin
                w_result[4*k +: 4] = BCD_BLANK;
            end else begin
                w_lead = 1'b0;
            end
        end
`endif
        if (r_ovf_flag) begin
            w_result = {DIGITS{4'h9}};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                o_out_valid = 1'b1;
                if (i_out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sr       <= '0;
            r_cnt      <= '0;
            r_ovf_flag <= 1'b0;
            r_bcd      <= BCD_RST;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_in_valid) begin
                        r_sr       <= SR_W'(i_in_data);
                        r_cnt      <= CNT_W'(IN_WIDTH);
                        r_ovf_flag <= w_over;
                    end
                end
                SHIFT: begin
                    r_sr  <= w_shifted;
                    r_cnt <= r_cnt - CNT_W'(1);
                    // Outputs only move on entry to DONE so the display holds steady.
                    if (w_last) begin
                        r_bcd      <= w_result;
                        r_overflow <= r_ovf_flag;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_bcd_out  = r_bcd;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_bcd_digit_encoder.sv
// tb/tb_bcd_digit_encoder.sv - scoreboard bench for bcd_digit_encoder (11-bit and 14-bit instances)
module tb_bcd_digit_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ovf;
    logic [10:0] a_in_data;
    logic [15:0] a_bcd;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ovf;
    logic [13:0] b_in_data;
    logic [15:0] b_bcd;

`ifdef BCD_LEADING_ZERO_BLANK_EN
    localparam logic [15:0] RST_BCD = 16'hFFF0;
`else
    localparam logic [15:0] RST_BCD = 16'h0000;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [16:0] qa[$];
    logic [16:0] qb[$];
    int a_rises[$];
    bit a_seen = 0;
    bit b_seen = 0;

    bcd_digit_encoder #(.IN_WIDTH(11), .DIGITS(4)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_in_valid(a_in_valid), .o_in_ready(a_in_ready), .i_in_data(a_in_data),
        .o_out_valid(a_out_valid), .i_out_ready(a_out_ready),
        .o_bcd_out(a_bcd), .o_overflow(a_ovf)
    );

    bcd_digit_encoder #(.IN_WIDTH(14), .DIGITS(4)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_in_valid(b_in_valid), .o_in_ready(b_in_ready), .i_in_data(b_in_data),
        .o_out_valid(b_out_valid), .i_out_ready(b_out_ready),
        .o_bcd_out(b_bcd), .o_overflow(b_ovf)
    );

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected {overflow, bcd} for a 4-digit converter, by decimal division.
    function automatic logic [16:0] model(input int v);
        logic [15:0] r;
        int t;
        bit lead;
        if (v > 9999) return {1'b1, 16'h9999};
        t = v;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
`ifdef BCD_LEADING_ZERO_BLANK_EN
        lead = 1'b1;
        for (int k = 3; k >= 1; k--) begin
            if (lead && r[4*k +: 4] == 4'd0) r[4*k +: 4] = 4'hF;
            else lead = 1'b0;
        end
`else
        lead = 1'b0;
`endif
        return {1'b0, r};
    endfunction

    always @(negedge clk) begin
        if (!rst_n || !a_out_valid) begin
            a_seen = 0;
        end else if (!a_seen) begin
            a_seen = 1;
            a_rises.push_back(cyc);
            if (qa.size() == 0) check("a_unexpected_result", {15'd0, a_ovf, a_bcd}, 32'hFFFF_FFFF);
            else check("a_result", {15'd0, a_ovf, a_bcd}, {15'd0, qa.pop_front()});
        end
    end

    always @(negedge clk) begin
        if (!rst_n || !b_out_valid) begin
            b_seen = 0;
        end else if (!b_seen) begin
            b_seen = 1;
            if (qb.size() == 0) check("b_unexpected_result", {15'd0, b_ovf, b_bcd}, 32'hFFFF_FFFF);
            else check("b_result", {15'd0, b_ovf, b_bcd}, {15'd0, qb.pop_front()});
        end
    end

    task automatic send_a(input int v);
        int n = 0;
        @(negedge clk);
        while (!a_in_ready && n < 100) begin @(negedge clk); n++; end
        check("a_send_ready", {31'd0, a_in_ready}, 32'd1);
        a_in_valid = 1'b1;
        a_in_data  = 11'(v);
        qa.push_back(model(v));
        @(posedge clk);
        #1 a_in_valid = 1'b0;
    endtask

    task automatic send_b(input int v);
        int n = 0;
        @(negedge clk);
        while (!b_in_ready && n < 100) begin @(negedge clk); n++; end
        check("b_send_ready", {31'd0, b_in_ready}, 32'd1);
        b_in_valid = 1'b1;
        b_in_data  = 14'(v);
        qb.push_back(model(v));
        @(posedge clk);
        #1 b_in_valid = 1'b0;
    endtask

    task automatic drain_a();
        int n = 0;
        while ((qa.size() != 0 || !a_in_ready) && n < 200) begin @(negedge clk); n++; end
        check("a_drain", qa.size(), 0);
    endtask

    task automatic drain_b();
        int n = 0;
        while ((qb.size() != 0 || !b_in_ready) && n < 200) begin @(negedge clk); n++; end
        check("b_drain", qb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int vals[3];
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_in_ready",  {31'd0, a_in_ready},  32'd1);
        check("rst_a_out_valid", {31'd0, a_out_valid}, 32'd0);
        check("rst_a_bcd",       {16'd0, a_bcd},       {16'd0, RST_BCD});
        check("rst_a_overflow",  {31'd0, a_ovf},       32'd0);
        check("rst_b_bcd",       {16'd0, b_bcd},       {16'd0, RST_BCD});
        check("rst_b_overflow",  {31'd0, b_ovf},       32'd0);
        rst_n = 1'b1;

        // Latency and hold with the consumer stalled.
        a_out_ready = 1'b0;
        send_a(1234);
        n = 0;
        while (!a_out_valid && n < 50) begin @(posedge clk); #1; n++; end
        check("a_latency", n, 11);
        repeat (10) begin
            @(negedge clk);
            check("a_hold_valid", {31'd0, a_out_valid}, 32'd1);
            check("a_hold_bcd", {16'd0, a_bcd}, 32'h1234);
            check("a_done_in_ready", {31'd0, a_in_ready}, 32'd0);
        end
        @(posedge clk); #1 a_out_ready = 1'b1;
        @(posedge clk); #1;
        check("a_ack_in_ready",  {31'd0, a_in_ready},  32'd1);
        check("a_ack_out_valid", {31'd0, a_out_valid}, 32'd0);
        check("a_idle_hold_bcd", {16'd0, a_bcd},       32'h1234);

        // Asynchronous reset in the middle of a conversion.
        send_a(1234);
        repeat (5) @(posedge clk);
        #1 check("a_shift_hold_bcd", {16'd0, a_bcd}, 32'h1234);
        rst_n = 1'b0;
        qa.delete();
        qb.delete();
        #1;
        check("midrst_in_ready",  {31'd0, a_in_ready},  32'd1);
        check("midrst_out_valid", {31'd0, a_out_valid}, 32'd0);
        check("midrst_bcd",       {16'd0, a_bcd},       {16'd0, RST_BCD});
        check("midrst_overflow",  {31'd0, a_ovf},       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_a(1234); drain_a();

        // Boundaries and leading-zero cases.
        send_a(0);    drain_a();
        send_a(2047); drain_a();
        send_a(7);    drain_a();
        send_a(1005); drain_a();
        send_b(9999);  drain_b();
        send_b(12000); drain_b();
        send_b(5);     drain_b();
        send_b(10000); drain_b();

        // in_data changing while busy must be ignored.
        @(negedge clk);
        a_in_valid = 1'b1;
        a_in_data  = 11'd321;
        qa.push_back(model(321));
        @(posedge clk);
        @(negedge clk);
        n = 0;
        while (!a_out_valid && n < 50) begin
            a_in_data = 11'($urandom);
            @(negedge clk);
            n++;
        end
        a_in_valid = 1'b0;
        drain_a();

        // Back-to-back with out_ready held high.
        vals = '{1999, 42, 800};
        a_rises.delete();
        for (int i = 0; i < 3; i++) begin
            n = 0;
            @(negedge clk);
            while (!a_in_ready && n < 50) begin @(negedge clk); n++; end
            a_in_data  = 11'(vals[i]);
            a_in_valid = 1'b1;
            qa.push_back(model(vals[i]));
            @(posedge clk);
        end
        #1 a_in_valid = 1'b0;
        drain_a();
        check("b2b_results", a_rises.size(), 3);
        if (a_rises.size() >= 3) begin
            check("b2b_period_0", a_rises[1] - a_rises[0], 13);
            check("b2b_period_1", a_rises[2] - a_rises[1], 13);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_digit_encoder.md
Name: bcd_digit_encoder

Overview:
- Sequential binary-to-BCD converter that sits directly upstream of the per-digit seven-segment decoders.
- Accepts an unsigned binary value over a valid/ready handshake and converts it with shift-add-3 (double dabble), one bit per clock.
- Presents DIGITS packed 4-bit BCD nibbles; each nibble drives one decoder's bcd input.
- Output is held stable between conversions so the displays never flicker.

Parameters:
- IN_WIDTH, 11, width of the binary input in bits (11 bits covers 0..2047).
- DIGITS, 4, number of BCD output digits; the representable maximum is 10^DIGITS - 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a value; high only in IDLE.
- in_data  input  IN_WIDTH  unsigned binary value to convert.
- out_valid  output  1  a new result is available; high only in DONE.
- out_ready  input  1  consumer acknowledges the result.
- bcd_out  output  4*DIGITS  packed BCD; digit 0 (ones) is in bits [3:0], and digit k is in bits [4k+3:4k].
- overflow  output  1  the last accepted value exceeded 10^DIGITS - 1.

Behaviour:
- Reset (async assert, whenever rst_n=0, including mid-conversion):
  - state goes to IDLE; in_ready=1, out_valid=0, overflow=0.
  - bcd_out = all zero digits; internal shift register and counter are cleared.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge T: latch in_data into the low end of the shift register, clear the BCD field, set bit counter=IN_WIDTH, and go to SHIFT.
  - Also at edge T, compute and latch the overflow compare (in_data > 10^DIGITS - 1).
- SHIFT:
  - in_ready=0.
  - Each cycle, for every BCD digit >= 5, add 3 to that digit. Then shift the whole {bcd, bin} register left by one bit and decrement the counter.
  - After IN_WIDTH shifts, at edge T+IN_WIDTH, go to DONE.
  - At the same edge, register bcd_out: the converted digits, or all digits = 9 when the overflow flag is set (saturating).
  - At the same edge, register overflow from the latched flag.
- DONE:
  - out_valid=1; bcd_out and overflow are stable.
  - On out_ready=1, go to IDLE at the next edge; out_valid drops.
  - in_ready=0 in DONE, so a new accept cannot occur in the same cycle as out_ready; the earliest new accept is the following cycle.
- Latency: out_valid rises exactly IN_WIDTH cycles after the accepting edge.
- Throughput: one result per IN_WIDTH+2 cycles when out_ready is held high.
- Hold behaviour: bcd_out and overflow retain the last result through IDLE and SHIFT. They change only on entry to DONE or on reset.
- in_valid while not in IDLE is ignored, and in_data is not sampled.
- Arithmetic:
  - The BCD field is 4*DIGITS bits wide; the shift register is 4*DIGITS+IN_WIDTH bits wide.
  - The add-3 correction is 4-bit and never carries out of a digit.
  - The 10^DIGITS - 1 limit is a localparam computed at elaboration.
- Boundaries:
  - in_data=0 gives all-zero digits.
  - in_data = 10^DIGITS - 1 gives all 9s with overflow=0.
  - in_data = 10^DIGITS gives all 9s with overflow=1, when IN_WIDTH allows such a value.

Optional Feature:
- Macro: BCD_LEADING_ZERO_BLANK_EN.
- When defined:
  - On entry to DONE, every zero digit above the most significant nonzero digit is replaced by 4'hF. Downstream decoders blank any code above 9.
  - Digit 0 is never blanked.
  - The reset value of bcd_out is digit 0 = 0 and all other digits = F.
  - Overflow saturation (all 9s) is unaffected.
- When undefined: leading zeros are output as 0, and the reset value is all zeros.

Decomposition:
- Shared package:
  - state enum {IDLE, SHIFT, DONE};
  - constant BCD_BLANK = 4'hF;
  - constant BCD_ADD3_THRESH = 4'd5.
- One sub-module, bcd_add3: purely combinational, 4-bit in, 4-bit out (adds 3 when input >= 5). It is instantiated DIGITS times in a generate loop.

Test Plan:
- Reset mid-SHIFT: accept 1234, assert rst_n=0 after 5 cycles -> immediately in_ready=1, out_valid=0, bcd_out=0x0000, overflow=0; the next accept converts correctly.
- Latency/value: accept 1234 at edge T -> out_valid=1 after edge T+11, bcd_out=0x1234, overflow=0; hold out_ready=0 for 10 cycles -> outputs stable; pulse out_ready -> IDLE next cycle.
- Boundaries: accept 0 -> 0x0000; accept 9999 with IN_WIDTH=14 -> 0x9999, overflow=0; accept 2047 with the default IN_WIDTH -> 0x2047.
- Overflow: IN_WIDTH=14, accept 12000 -> bcd_out=0x9999, overflow=1; the next accept of 5 -> 0x0005, overflow=0.
- Handshake: hold in_valid=1 with changing in_data during SHIFT/DONE -> only the value at the IDLE accept is converted; back-to-back with out_ready=1 gives a 13-cycle period.
- With BCD_LEADING_ZERO_BLANK_EN: accept 7 -> 0xFFF7; accept 0 -> 0xFFF0; accept 1005 -> 0x1005; after reset bcd_out=0xFFF0.
